// File: rtl/synth_pkg.sv
// Shared constants for the voice-path output stage: sample width, MCP4921
// write-frame config bits and the DAC writer FSM encoding.
package synth_pkg;

    localparam int SAMPLE_W = 12;
    localparam int FRAME_W  = 16;

    // MCP4921 write-command nibble, frame bits [15:12] = {A/B, BUF, GA, SHDN}
    localparam logic DAC_CFG_AB_A        = 1'b0;
    localparam logic DAC_CFG_BUF_OFF     = 1'b0;
    localparam logic DAC_CFG_GA_1X       = 1'b1;
    localparam logic DAC_CFG_SHDN_ACTIVE = 1'b1;
    localparam logic [3:0] DAC_CONFIG_DEFAULT =
        {DAC_CFG_AB_A, DAC_CFG_BUF_OFF, DAC_CFG_GA_1X, DAC_CFG_SHDN_ACTIVE};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CS_END = 2'd2,
        ST_LDAC   = 2'd3
    } dacState_e;

endpackage

// File: rtl/sample_rate_timer.sv
// Free-running sample-rate timebase: counts 0..SAMPLE_PERIOD-1 and emits a
// registered one-clock tick during the cycle in which the count is at its top.
module sample_rate_timer #(
    parameter int SAMPLE_PERIOD = 1134
) (
    input  logic inClock,
    input  logic inResetN,
    output logic outTick
);

    localparam int CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(SAMPLE_PERIOD - 2);

    if (SAMPLE_PERIOD < 2) begin : gBadPeriod
        $error("sample_rate_timer: SAMPLE_PERIOD must be at least 2");
    end

    logic [CNT_W-1:0] count;

    // The tick is decoded one count early so it comes straight from a flop
    always_ff @(posedge inClock) begin
        if (!inResetN) begin
            count   <= '0;
            outTick <= 1'b0;
        end else begin
            count   <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
            outTick <= (count == CNT_PRE_LAST);
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// Voice-path output stage: owns the sample timebase and writes each captured
// sample to an MCP4921-class DAC as one 16-bit SPI frame followed by LDAC.
module dac_spi_writer
    import synth_pkg::*;
#(
    parameter int         SAMPLE_PERIOD = 1134,
    parameter int         CLK_DIV       = 2,
    parameter logic [3:0] DAC_CONFIG    = DAC_CONFIG_DEFAULT
) (
    input  logic                inClock,
    input  logic                inResetN,
    input  logic [SAMPLE_W-1:0] inSample,
    input  logic                inMute,
    output logic                outSampleReady,
    output logic                outDacCsN,
    output logic                outDacSck,
    output logic                outDacSdi,
    output logic                outDacLdacN,
    output logic                outBusy
);

    localparam int PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : gBadClkDiv
        $error("dac_spi_writer: CLK_DIV must be at least 1");
    end
    if (SAMPLE_PERIOD <= 34 * CLK_DIV + 1) begin : gBadPeriod
        $error("dac_spi_writer: SAMPLE_PERIOD too short for one frame");
    end

    dacState_e          state;
    logic [PHASE_W-1:0] phaseCnt;
    logic [3:0]         bitCnt;
    logic [FRAME_W-1:0] shiftReg;
    logic               tick;

    sample_rate_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) uTimer (
        .inClock (inClock),
        .inResetN(inResetN),
        .outTick (tick)
    );

    assign outSampleReady = tick;
    // Zeros shift in behind the frame, so SDI returns low once the last bit has gone
    assign outDacSdi      = shiftReg[FRAME_W-1];

    always_ff @(posedge inClock) begin
        if (!inResetN) begin
            state       <= ST_IDLE;
            phaseCnt    <= '0;
            bitCnt      <= 4'd15;
            shiftReg    <= '0;
            outDacCsN   <= 1'b1;
            outDacSck   <= 1'b0;
            outDacLdacN <= 1'b1;
            outBusy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        shiftReg  <= {DAC_CONFIG, inMute ? {SAMPLE_W{1'b0}} : inSample};
                        state     <= ST_SHIFT;
                        phaseCnt  <= '0;
                        bitCnt    <= 4'd15;
                        outDacCsN <= 1'b0;
                        outDacSck <= 1'b0;
                        outBusy   <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (phaseCnt == PHASE_LAST) begin
                        phaseCnt <= '0;
                        if (!outDacSck) begin
                            outDacSck <= 1'b1;
                        end else begin
                            outDacSck <= 1'b0;
                            shiftReg  <= {shiftReg[FRAME_W-2:0], 1'b0};
                            if (bitCnt == 4'd0) begin
                                state     <= ST_CS_END;
                                outDacCsN <= 1'b1;
                            end else begin
                                bitCnt <= bitCnt - 4'd1;
                            end
                        end
                    end else begin
                        phaseCnt <= phaseCnt + PHASE_W'(1);
                    end
                end

                ST_CS_END: begin
                    if (phaseCnt == PHASE_LAST) begin
                        phaseCnt    <= '0;
                        state       <= ST_LDAC;
                        outDacLdacN <= 1'b0;
                    end else begin
                        phaseCnt <= phaseCnt + PHASE_W'(1);
                    end
                end

                ST_LDAC: begin
                    if (phaseCnt == PHASE_LAST) begin
                        phaseCnt    <= '0;
                        state       <= ST_IDLE;
                        outDacLdacN <= 1'b1;
                        outBusy     <= 1'b0;
                    end else begin
                        phaseCnt <= phaseCnt + PHASE_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: drives samples on each strobe, decodes the SPI
// frames seen on the DAC pins and compares them with a queue of expected frames.
module tb_dac_spi_writer;

    localparam int SP = 100;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        inResetN = 1'b0;
    logic [11:0] inSample = '0;
    logic        inMute = 1'b0;
    logic        outSampleReady, outDacCsN, outDacSck, outDacSdi, outDacLdacN, outBusy;

    int assertCount = 0;
    int failCount   = 0;
    int cyc = 0;
    int framesGood = 0;
    int ldacPulses = 0;
    logic monEn = 1'b0;
    logic abortPending = 1'b0;
    logic [15:0] exp_q[$];

    dac_spi_writer #(.SAMPLE_PERIOD(SP), .CLK_DIV(CD)) dut (
        .inClock       (clk),
        .inResetN      (inResetN),
        .inSample      (inSample),
        .inMute        (inMute),
        .outSampleReady(outSampleReady),
        .outDacCsN     (outDacCsN),
        .outDacSck     (outDacSck),
        .outDacSdi     (outDacSdi),
        .outDacLdacN   (outDacLdacN),
        .outBusy       (outBusy)
    );

    // clock and cycle count (cyc == 0 in the cycle after the last reset edge)
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (!inResetN) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI monitor / scoreboard, sampled on the falling clock edge
    logic        prevSck = 1'b0, prevCsN = 1'b1, prevLdacN = 1'b1, prevBusy = 1'b0, prevStrobe = 1'b0;
    logic [15:0] shiftIn = '0;
    int          riseCnt = 0, sckHighLen = 0, ldacLen = 0, busyLen = 0;

    always @(negedge clk) begin
        if (monEn) begin
            automatic logic aborting = abortPending;
            checkVal("strobe_timing", outSampleReady, (cyc % SP) == SP - 1);
            if (prevStrobe) checkVal("csn_fall_after_strobe", outDacCsN, 1'b0);

            if (!outDacCsN && outDacSck && !prevSck) begin
                shiftIn = {shiftIn[14:0], outDacSdi};
                riseCnt++;
            end
            if (outDacSck) begin
                sckHighLen++;
            end else if (prevSck) begin
                if (!aborting) checkVal("sck_high_width", sckHighLen, CD);
                sckHighLen = 0;
            end

            if (outDacCsN && !prevCsN) begin
                if (aborting) begin
                    void'(exp_q.pop_front());
                    abortPending = 1'b0;
                end else if (exp_q.size() == 0) begin
                    checkVal("unexpected_frame", 1, 0);
                end else begin
                    checkVal("sck_rises", riseCnt, 16);
                    checkVal("frame_data", {16'h0, shiftIn}, {16'h0, exp_q.pop_front()});
                end
                riseCnt = 0;
                shiftIn = '0;
            end

            if (!outDacLdacN) begin
                ldacLen++;
            end else if (!prevLdacN) begin
                checkVal("ldac_width", ldacLen, CD);
                ldacPulses++;
                ldacLen = 0;
            end

            if (outBusy) begin
                busyLen++;
            end else if (prevBusy) begin
                if (!aborting) checkVal("busy_length", busyLen, 34 * CD);
                busyLen = 0;
            end

            prevSck    = outDacSck;
            prevCsN    = outDacCsN;
            prevLdacN  = outDacLdacN;
            prevBusy   = outBusy;
            prevStrobe = outSampleReady;
        end
    end

    task automatic waitStrobe();
        automatic bit seen = 1'b0;
        for (int i = 0; i < 2 * SP; i++) begin
            @(negedge clk);
            if (outSampleReady) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkVal("strobe_timeout", 0, 1);
    endtask

    // drive one sample at the strobe; optionally scramble inputs during the frame
    task automatic sendFrame(input logic [11:0] sample, input logic mute, input bit scramble);
        waitStrobe();
        inSample = sample;
        inMute   = mute;
        exp_q.push_back({4'h3, mute ? 12'h000 : sample});
        @(posedge clk);
        if (scramble) begin
            for (int i = 0; i < 34 * CD; i++) begin
                @(negedge clk);
                inSample = 12'($urandom_range(0, 4095));
                inMute   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, "_csn"},   outDacCsN, 1'b1);
        checkVal({tag, "_sck"},   outDacSck, 1'b0);
        checkVal({tag, "_sdi"},   outDacSdi, 1'b0);
        checkVal({tag, "_ldacn"}, outDacLdacN, 1'b1);
        checkVal({tag, "_busy"},  outBusy, 1'b0);
        checkVal({tag, "_ready"}, outSampleReady, 1'b0);
    endtask

    initial begin
        inResetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        inResetN = 1'b1;
        monEn    = 1'b1;

        sendFrame(12'hABC, 1'b0, 1'b0);
        framesGood++;
        sendFrame(12'hFFF, 1'b1, 1'b0);
        framesGood++;
        sendFrame(12'h001, 1'b0, 1'b1);
        framesGood++;
        for (int i = 0; i < 4; i++) begin
            sendFrame(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) == 0), 1'b1);
            framesGood++;
        end

        // abandon a frame during bit 7 (bit k starts 4*(15-k) cycles into the frame)
        sendFrame(12'h5A5, 1'b0, 1'b0);
        repeat (34) @(negedge clk);
        abortPending = 1'b1;
        inResetN     = 1'b0;
        @(negedge clk);
        checkIdleOutputs("abort");
        inResetN = 1'b1;

        sendFrame(12'h7E1, 1'b0, 1'b1);
        framesGood++;
        sendFrame(12'h800, 1'b1, 1'b0);
        framesGood++;
        repeat (SP) @(negedge clk);

        checkVal("queue_empty", exp_q.size(), 0);
        checkVal("ldac_pulse_count", ldacPulses, framesGood);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
